// File: rtl/store_drain_unit_pkg.sv
// Shared encodings for the store drain unit: TileLink-UL opcodes, drain FSM states
// and the latched store payload.
package store_drain_unit_pkg;

  localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] TL_ACCESS_ACK       = 3'd0;
  localparam logic [1:0] TL_SIZE_WORD        = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } drain_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  bm;
    logic        io;
  } store_payload_t;

  // A full byte mask is a PutFullData, anything narrower is a partial put.
  function automatic logic [2:0] put_opcode(input logic [3:0] bm);
    return (bm == 4'hF) ? TL_PUT_FULL_DATA : TL_PUT_PARTIAL_DATA;
  endfunction

endpackage

// File: rtl/store_drain_unit.sv
// Drains the oldest committed store: TileLink-UL Put on A, write-through cache update, retire pulse.
// Latency: 3 cycles minimum from IDLE acceptance to cache_done_o; one store in flight at a time.
// Backpressure: A request held stable until a_ready_i; head input is sampled only in IDLE.
module store_drain_unit
  import store_drain_unit_pkg::*;
#(
  parameter int PHYS      = 32,
  parameter int SOURCE_ID = 0
) (
  input  logic            cpu_clk_i,
  input  logic            cpu_rst_ni,
  input  logic            store_valid_i,
  input  logic [PHYS-3:0] store_address_i,
  input  logic [31:0]     store_data_i,
  input  logic [3:0]      store_bm_i,
  input  logic            store_io_i,
  output logic            cache_done_o,
  output logic            dc_wr_o,
  output logic [PHYS-3:0] dc_wr_address_o,
  output logic [31:0]     dc_wr_data_o,
  output logic [3:0]      dc_wr_bm_o,
  output logic            a_valid_o,
  input  logic            a_ready_i,
  output logic [2:0]      a_opcode_o,
  output logic [1:0]      a_size_o,
  output logic [2:0]      a_source_o,
  output logic [PHYS-1:0] a_address_o,
  output logic [3:0]      a_mask_o,
  output logic [31:0]     a_data_o,
  input  logic            d_valid_i,
  output logic            d_ready_o,
  input  logic            d_denied_i,
  output logic            store_fault_o,
  output logic            drain_idle_o
);

  drain_state_e    state_q, state_d;
  logic [PHYS-3:0] addr_q, addr_d;
  store_payload_t  payload_q, payload_d;
  logic            fault_q, fault_d;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    payload_d     = payload_q;
    fault_d       = fault_q;
    a_valid_o     = 1'b0;
    d_ready_o     = 1'b0;
    cache_done_o  = 1'b0;
    dc_wr_o       = 1'b0;
    store_fault_o = 1'b0;
    drain_idle_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        drain_idle_o = 1'b1;
        if (store_valid_i) begin
          addr_d         = store_address_i;
          payload_d.data = store_data_i;
          payload_d.bm   = store_bm_i;
          payload_d.io   = store_io_i;
          fault_d        = 1'b0;
          state_d        = ST_REQ;
        end
      end
      ST_REQ: begin
        a_valid_o = 1'b1;
        if (a_ready_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // D is only accepted once the A beat has gone, never alongside it.
        d_ready_o = 1'b1;
        if (d_valid_i) begin
          fault_d = d_denied_i;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Retire and cache update share this cycle so younger loads always find the data.
        cache_done_o  = 1'b1;
        dc_wr_o       = !payload_q.io && !fault_q;
        store_fault_o = fault_q;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      payload_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      payload_q <= payload_d;
      fault_q   <= fault_d;
    end
  end

  assign a_opcode_o      = put_opcode(payload_q.bm);
  assign a_size_o        = TL_SIZE_WORD;
  assign a_source_o      = 3'(SOURCE_ID);
  assign a_address_o     = {addr_q, 2'b00};
  assign a_mask_o        = payload_q.bm;
  assign a_data_o        = payload_q.data;

  assign dc_wr_address_o = addr_q;
  assign dc_wr_data_o    = payload_q.data;
  assign dc_wr_bm_o      = payload_q.bm;

endmodule

// File: tb/tb_store_drain_unit.sv
// Directed scoreboard bench for store_drain_unit: A requests and retire results are queued
// when a store is presented and checked when the design produces them.
module tb_store_drain_unit;

  localparam int PHYS = 32;

  logic            cpu_clk_i = 1'b0;
  logic            cpu_rst_ni = 1'b0;
  logic            store_valid_i = 1'b0;
  logic [PHYS-3:0] store_address_i = '0;
  logic [31:0]     store_data_i = '0;
  logic [3:0]      store_bm_i = '0;
  logic            store_io_i = 1'b0;
  logic            cache_done_o;
  logic            dc_wr_o;
  logic [PHYS-3:0] dc_wr_address_o;
  logic [31:0]     dc_wr_data_o;
  logic [3:0]      dc_wr_bm_o;
  logic            a_valid_o;
  logic            a_ready_i = 1'b0;
  logic [2:0]      a_opcode_o;
  logic [1:0]      a_size_o;
  logic [2:0]      a_source_o;
  logic [PHYS-1:0] a_address_o;
  logic [3:0]      a_mask_o;
  logic [31:0]     a_data_o;
  logic            d_valid_i = 1'b0;
  logic            d_ready_o;
  logic            d_denied_i = 1'b0;
  logic            store_fault_o;
  logic            drain_idle_o;

  store_drain_unit #(.PHYS(PHYS), .SOURCE_ID(0)) dut (
    .cpu_clk_i       (cpu_clk_i),
    .cpu_rst_ni      (cpu_rst_ni),
    .store_valid_i   (store_valid_i),
    .store_address_i (store_address_i),
    .store_data_i    (store_data_i),
    .store_bm_i      (store_bm_i),
    .store_io_i      (store_io_i),
    .cache_done_o    (cache_done_o),
    .dc_wr_o         (dc_wr_o),
    .dc_wr_address_o (dc_wr_address_o),
    .dc_wr_data_o    (dc_wr_data_o),
    .dc_wr_bm_o      (dc_wr_bm_o),
    .a_valid_o       (a_valid_o),
    .a_ready_i       (a_ready_i),
    .a_opcode_o      (a_opcode_o),
    .a_size_o        (a_size_o),
    .a_source_o      (a_source_o),
    .a_address_o     (a_address_o),
    .a_mask_o        (a_mask_o),
    .a_data_o        (a_data_o),
    .d_valid_i       (d_valid_i),
    .d_ready_o       (d_ready_o),
    .d_denied_i      (d_denied_i),
    .store_fault_o   (store_fault_o),
    .drain_idle_o    (drain_idle_o)
  );

  always #5 cpu_clk_i = ~cpu_clk_i;

  // {opcode, size, source, address, mask, data}
  logic [75:0] a_q[$];
  // {dc_wr, fault, address, data, bm}; cache fields zero when no write is expected
  logic [67:0] done_q[$];

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_hs  = 0;
  logic        mon_vld = 1'b0;
  logic [75:0] mon_a = '0;

  task automatic chk(input string tag, input logic [127:0] obs_v, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic logic [75:0] a_obs();
    return {a_opcode_o, a_size_o, a_source_o, a_address_o, a_mask_o, a_data_o};
  endfunction

  // Advance to the next falling edge and run the scoreboard monitor.
  task automatic step();
    logic        hold;
    logic        hs;
    logic [67:0] ed;
    logic [67:0] od;
    hold = mon_vld && !a_ready_i;
    hs   = mon_vld && a_ready_i;
    if (hs) begin
      n_hs++;
      if (a_q.size() == 0) chk("a_unexpected", 128'(1), 128'(0));
      else                 chk("a_req", 128'(mon_a), 128'(a_q.pop_front()));
    end
    @(negedge cpu_clk_i);
    if (cpu_rst_ni) begin
      if (hold) chk("a_hold", 128'({a_valid_o, a_obs()}), 128'({1'b1, mon_a}));
      if (cache_done_o) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 128'(1), 128'(0));
        end else begin
          ed = done_q.pop_front();
          od = {dc_wr_o, store_fault_o, dc_wr_address_o, dc_wr_data_o, dc_wr_bm_o};
          if (!ed[67]) od[65:0] = '0;
          chk("retire", 128'(od), 128'(ed));
        end
      end else begin
        chk("stray_pulse", 128'({dc_wr_o, store_fault_o}), 128'(2'b00));
      end
    end
    mon_vld = cpu_rst_ni && a_valid_o;
    mon_a   = a_obs();
  endtask

  task automatic do_store(input logic [29:0] addr, input logic [31:0] data, input logic [3:0] bm,
                          input logic io, input logic denied, input int stall, input int exp_n,
                          input bit keep);
    int  n;
    int  left;
    int  base;
    bit  done;
    logic wr;
    wr = !io && !denied;
    a_q.push_back({((bm == 4'hF) ? 3'd0 : 3'd1), 2'd2, 3'd0, {addr, 2'b00}, bm, data});
    done_q.push_back({wr, denied, (wr ? {addr, data, bm} : 66'd0)});
    store_valid_i   = 1'b1;
    store_address_i = addr;
    store_data_i    = data;
    store_bm_i      = bm;
    store_io_i      = io;
    d_denied_i      = denied;
    d_valid_i       = 1'b1;
    a_ready_i       = (stall == 0);
    left = stall;
    base = exp_n - 3 - stall;
    n    = 0;
    done = 0;
    while (!done && n < 40) begin
      step();
      n++;
      if (cache_done_o) begin
        done = 1;
      end else begin
        chk("a_valid", 128'(a_valid_o), 128'(n > base && n <= base + 1 + stall));
        chk("d_ready", 128'(d_ready_o), 128'(n == exp_n - 1));
        chk("drain_idle", 128'(drain_idle_o), 128'(n <= base));
      end
      if (a_valid_o) begin
        if (left > 0) begin
          left--;
          a_ready_i = 1'b0;
        end else begin
          a_ready_i = 1'b1;
        end
      end
    end
    chk("latency", 128'(n), 128'(exp_n));
    if (!keep) store_valid_i = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset_outputs", 128'({a_valid_o, cache_done_o, dc_wr_o, store_fault_o, d_ready_o, drain_idle_o}),
        128'(6'b000001));
    step();
    step();
    cpu_rst_ni = 1'b1;
    step();

    // Full-word cacheable store at byte 0x1000, no stalls.
    do_store(30'h400, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 0, 3, 1'b0);
    step();
    // Partial uncached store: partial opcode, no cache write.
    do_store(30'h0123, 32'h0000_A55A, 4'h3, 1'b1, 1'b0, 0, 3, 1'b0);
    step();
    // A-channel backpressure for five cycles.
    do_store(30'h2_0040, 32'h1234_5678, 4'hC, 1'b0, 1'b0, 5, 8, 1'b0);
    step();
    // Back-to-back with valid held through the retire edge.
    do_store(30'h11, 32'hCAFE_0001, 4'hF, 1'b0, 1'b0, 0, 3, 1'b1);
    do_store(30'h12, 32'hCAFE_0002, 4'h1, 1'b0, 1'b0, 0, 4, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("handshakes_b2b", 128'(n_hs), 128'(5));
    // Denied response still retires and flags a fault.
    do_store(30'h3FF, 32'hBAD0_BAD0, 4'hF, 1'b0, 1'b1, 0, 3, 1'b0);
    step();

    // Reset while waiting for the D response.
    a_q.push_back({3'd0, 2'd2, 3'd0, {30'h55, 2'b00}, 4'hF, 32'h5555_AAAA});
    store_valid_i   = 1'b1;
    store_address_i = 30'h55;
    store_data_i    = 32'h5555_AAAA;
    store_bm_i      = 4'hF;
    store_io_i      = 1'b0;
    d_denied_i      = 1'b0;
    d_valid_i       = 1'b0;
    a_ready_i       = 1'b1;
    step();
    step();
    step();
    chk("resp_d_ready", 128'({d_ready_o, a_valid_o}), 128'(2'b10));
    #2;
    cpu_rst_ni    = 1'b0;
    store_valid_i = 1'b0;
    #1;
    chk("async_reset", 128'({a_valid_o, cache_done_o, dc_wr_o, store_fault_o, d_ready_o, drain_idle_o}),
        128'(6'b000001));
    step();
    step();
    cpu_rst_ni = 1'b1;
    step();
    chk("post_reset_idle", 128'(drain_idle_o), 128'(1));
    do_store(30'h66, 32'h0F0F_F0F0, 4'h6, 1'b0, 1'b0, 0, 3, 1'b0);

    for (int i = 0; i < 5; i++) step();
    chk("handshakes_total", 128'(n_hs), 128'(8));
    chk("queues_drained", 128'({a_q.size() == 0, done_q.size() == 0}), 128'(2'b11));
    chk("final_idle", 128'(drain_idle_o), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_drain_unit.md
Name: store_drain_unit

Overview:
- Sits directly downstream of the store buffer. Takes its oldest committed (non-speculative) store and performs it.
- Writes to the external bus as a TileLink-UL Put on the A channel. Cacheable stores also update the write-through data cache.
- Returns a single-cycle cache_done to the store buffer so that it retires the entry.
- Exactly one store is in flight at a time.

Parameters:
- PHYS, 32, physical address width; store word addresses are PHYS-2 bits.
- SOURCE_ID, 0, value driven on a_source; 3-bit field.

Ports:
- cpu_clk_i  in  1  core clock
- cpu_rst_ni  in  1  asynchronous active-low reset
- store_valid_i  in  1  store buffer head is non-speculative and ready
- store_address_i  in  PHYS-2  word address
- store_data_i  in  32  store data
- store_bm_i  in  4  byte mask
- store_io_i  in  1  uncached/IO store
- cache_done_o  out  1  one-cycle pulse that retires the head entry
- dc_wr_o  out  1  data-cache write-update strobe
- dc_wr_address_o  out  PHYS-2  cache update word address
- dc_wr_data_o  out  32  cache update data
- dc_wr_bm_o  out  4  cache update byte mask
- a_valid_o  out  1  TileLink A valid
- a_ready_i  in  1  TileLink A ready
- a_opcode_o  out  3  0 = PutFullData, 1 = PutPartialData
- a_size_o  out  2  always 2
- a_source_o  out  3  SOURCE_ID
- a_address_o  out  PHYS  {address, 2'b00}
- a_mask_o  out  4  byte mask
- a_data_o  out  32  data
- d_valid_i  in  1  TileLink D valid
- d_ready_o  out  1  TileLink D ready
- d_denied_i  in  1  bus error on the response
- store_fault_o  out  1  one-cycle pulse on a denied response
- drain_idle_o  out  1  FSM is in IDLE

Behaviour:
- Reset (asynchronous, cpu_rst_ni low):
  - FSM goes to IDLE.
  - cache_done_o, dc_wr_o, a_valid_o, store_fault_o = 0; drain_idle_o = 1.
  - Latched request registers are don't-care.
  - Reset mid-transaction abandons the transaction with no pulses. The bus and the store buffer are reset together.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If store_valid_i: latch address, data, bm and io; go to REQ.
  - The input is sampled only in IDLE. The store buffer holds the head stable until cache_done, so the latch is a copy only.
- REQ:
  - a_valid_o = 1 with the latched fields.
  - a_opcode_o = (bm == 4'hF) ? 0 : 1.
  - a_valid_o and all A fields stay stable until a_ready_i.
  - On a_valid_o & a_ready_i, go to RESP.
  - a_valid_o is never dropped before the handshake.
- RESP:
  - d_ready_o = 1.
  - On d_valid_i, go to DONE and register a fault bit = d_denied_i.
  - A d_valid_i in the same cycle as the A handshake is not accepted; d_ready_o is 0 outside RESP.
- DONE (exactly one cycle, then IDLE):
  - cache_done_o = 1.
  - dc_wr_o = !io & !fault, driving the latched address, data and bm.
  - store_fault_o = fault.
- Minimum latency from store_valid_i (IDLE) to cache_done_o is 3 cycles: IDLE, REQ with a_ready, RESP with d_valid, then DONE.
- No double retire:
  - The store buffer clears the head at the DONE clock edge.
  - The entry still visible during DONE is not re-accepted, because the FSM is not in IDLE.
  - Back-to-back stores give a new IDLE acceptance in the cycle after DONE.
- The cache update is issued in DONE, together with removal from the store buffer. Younger loads therefore see the data either through forwarding or in the cache, never neither.
- flush_i is not an input: committed stores always drain.
- drain_idle_o = (state == IDLE). Fences combine it with the store buffer's no_nonspec.
- A denied store still retires (cache_done_o = 1) and raises store_fault_o. The cache is not written.

Decomposition:
- Shared package holds:
  - TileLink opcode constants: PutFullData = 3'd0, PutPartialData = 3'd1, AccessAck = 3'd0.
  - The FSM state enum (2-bit).
- Single flat module; no sub-module is needed.

Test Plan:
- Single cacheable store (addr 0x0000_1000, data 0xDEADBEEF, bm 0xF); a_ready and d_valid each on their first possible cycle:
  - a_opcode = 0, a_address = 0x1000.
  - cache_done and dc_wr pulse once, 3 cycles after acceptance.
- Partial IO store (bm 0x3, io = 1):
  - a_opcode = 1, a_mask = 0x3.
  - cache_done pulses; dc_wr stays 0.
- A-channel backpressure (a_ready low for 5 cycles):
  - a_valid stays high, with address, data and mask unchanged every cycle.
  - Exactly one handshake occurs.
- Two back-to-back stores with store_valid held high:
  - Two distinct A requests in order.
  - cache_done pulses twice; no third request.
- Denied response (d_denied = 1):
  - store_fault and cache_done pulse together; dc_wr = 0.
- cpu_rst_ni asserted while in RESP:
  - Outputs are at reset values immediately (asynchronously).
  - After release, drain_idle = 1 and a new store is accepted normally.
